blink_timer_array: RTL and testbench
====================================

Name: blink_timer_array

Overview:
- Multi-channel programmable LED/timebase generator; next generation of the fixed 30 MHz to 1 Hz divider.
- Each channel has its own runtime-programmable period, high time and mode (off, on, free-running blink, N-pulse burst).
- Sits between the board clock and the LED pins and status indicators.
- Drives LEDs directly and also emits per-channel period ticks for other logic.

Parameters:
- CLK_HZ, 30_000_000, input clock frequency; sets the reset-default period.
- NUM_CH, 4, number of independent channels (1..16).
- CNT_W, 25, counter, period and high-time width; must satisfy 2^CNT_W > CLK_HZ.
- BURST_W, 8, burst pulse-count width.

Ports:
- clk_30mhz  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- cfg_period  in  CNT_W  period in clk_30mhz cycles.
- cfg_high  in  CNT_W  cycles the output is high per period.
- cfg_count  in  BURST_W  pulses per burst (BURST mode only).
- led_out  out  NUM_CH  registered channel outputs.
- tick  out  NUM_CH  one-cycle pulse on the last cycle of each period.
- burst_done  out  NUM_CH  one-cycle pulse when a burst completes.
- pending  out  NUM_CH  a deferred BLINK config is waiting for a period boundary.

Behaviour:
- Reset (async assert, sync deassert at the block boundary):
  - Every channel: mode=BLINK, period=CLK_HZ, high=CLK_HZ/2, counter=0.
  - led_out=0, tick=0, burst_done=0, pending=0.
  - This reproduces 1 Hz, 50 % duty on every channel.
  - Reset mid-operation discards all active, shadow and burst state.
- Counter, per channel:
  - Counts 0..period-1, then wraps to 0.
  - Runs only in BLINK and BURST; held at 0 in OFF and ON.
- Output timing:
  - led_out is registered.
  - Next-state value is (counter < high) in BLINK/BURST, 0 in OFF, 1 in ON.
  - One cycle of latency from counter to pin.
- Boundaries:
  - period=0 behaves as OFF: output 0, counter held, no tick.
  - high=0 gives constant low with ticks.
  - high>=period gives constant high with ticks.
- tick[i] is asserted in the cycle where counter==period-1 and the mode is BLINK or BURST.
- Config write (cfg_we=1, cfg_ch<NUM_CH; writes with cfg_ch>=NUM_CH are ignored):
  - If the new mode is OFF, ON or BURST, or the current mode is not BLINK: apply immediately.
    - The active registers load on that edge and the counter restarts at 0.
    - led_out reflects the new config one edge later.
  - If current and new mode are both BLINK: capture into the shadow and set pending[i].
    - The shadow applies on the edge where the counter wraps.
    - pending clears on that same edge.
    - This gives glitch-free period/duty changes.
  - A second write to the same channel while pending overwrites the shadow (latest wins).
  - An immediate write while pending discards the shadow and clears pending.
- BURST:
  - Entry loads remaining=cfg_count.
  - Each wrap decrements remaining.
  - On the wrap where remaining goes 1 to 0: mode becomes OFF, burst_done pulses on the same cycle as the final tick, and led_out goes 0 on the next edge.
  - cfg_count=0: mode becomes OFF next edge, burst_done pulses once, no tick.
- Simultaneous write and wrap on the same channel: the write wins.
  - Immediate write: restart.
  - BLINK-to-BLINK write: the new config applies at the next wrap, not the current one.
- Channels are fully independent; one cfg write per cycle.

Optional Feature:
- Macro BLINK_SYNC_EN.
- Defined:
  - Adds input port sync_in (1 bit).
  - sync_in=1 forces every BLINK/BURST channel counter to 0 on that edge.
  - Pending shadows apply on that edge.
  - No tick and no burst decrement for the interrupted period.
  - Purpose: phase-align all LEDs.
- Undefined:
  - The port does not exist.
  - Counters are only restarted by config writes and reset.

Decomposition:
- Package blink_pkg:
  - Mode encoding constants MODE_OFF, MODE_ON, MODE_BLINK, MODE_BURST.
  - 2-bit mode typedef.
  - Default period/high derivation from CLK_HZ.
- Sub-module blink_channel:
  - One per channel via generate.
  - Contains counter, active and shadow regs, burst counter, output register.
- Top level: cfg_ch decode, write-enable fan-out, output concatenation.

Test Plan (bench overrides CLK_HZ=20, CNT_W=8, NUM_CH=4):
- Reset release, no writes -> all led_out toggle with 10 cycles high / 10 low; tick every 20 cycles, aligned across channels.
- Write ch1 BLINK period=8 high=3 mid-period -> pending[1]=1 until the old period wraps; afterwards a 3-high/5-low pattern.
- Second BLINK write to ch1 before the wrap -> pending[1] stays 1 and the second config applies at the wrap.
- Write ch2 BURST period=4 high=2 count=3 -> exactly 3 pulses of 2 cycles, then led_out[2]=0 and burst_done[2] pulses once; count=0 -> burst_done next cycle, no pulses.
- Edge cases:
  - Write ch0 period=0 -> output held low, no ticks.
  - period=5 high=9 -> constant high with a tick every 5 cycles.
  - cfg_ch=5 write -> no channel changes.
- Assert rst_n low mid-burst with pending set -> outputs clear asynchronously; after release, default 1 Hz-equivalent behaviour.
- With BLINK_SYNC_EN defined: pulse sync_in with counters out of phase -> all channel counters restart at 0 on that edge, no tick for the interrupted period, and subsequent ticks coincide for channels with equal periods.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared mode encoding and reset-default timing for the blink timer array.
package blink_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF   = 2'd0;
    localparam mode_t MODE_ON    = 2'd1;
    localparam mode_t MODE_BLINK = 2'd2;
    localparam mode_t MODE_BURST = 2'd3;

    // Reset default is a 1 Hz, 50 % duty blink.
    function automatic int unsigned default_period(input int unsigned clk_hz);
        return clk_hz;
    endfunction

    function automatic int unsigned default_high(input int unsigned clk_hz);
        return clk_hz / 2;
    endfunction

endpackage

// File: rtl/blink_channel.sv
// One blink/burst channel: period counter, active and shadow config, burst counter and
// registered LED output.
module blink_channel
    import blink_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 30_000_000,
    parameter int unsigned CNT_W   = 25,
    parameter int unsigned BURST_W = 8
) (
    input  logic               clk_30mhz,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  mode_t              cfg_mode,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_count,
    input  logic               sync_in,
    output logic               led_out,
    output logic               tick,
    output logic               burst_done,
    output logic               pending
);

    localparam logic [CNT_W-1:0] DefPeriod = CNT_W'(default_period(CLK_HZ));
    localparam logic [CNT_W-1:0] DefHigh   = CNT_W'(default_high(CLK_HZ));

    mode_t              mode_q, mode_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]   sh_period_q, sh_period_d;
    logic [CNT_W-1:0]   sh_high_q, sh_high_d;
    logic               pend_q, pend_d;
    logic               led_q, led_d;

    logic counting, burst_empty, run, wrap, last, immediate, deferred, restart;

    always_ff @(posedge clk_30mhz or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_BLINK;
            period_q    <= DefPeriod;
            high_q      <= DefHigh;
            cnt_q       <= '0;
            rem_q       <= '0;
            sh_period_q <= '0;
            sh_high_q   <= '0;
            pend_q      <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            period_q    <= period_d;
            high_q      <= high_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            sh_period_q <= sh_period_d;
            sh_high_q   <= sh_high_d;
            pend_q      <= pend_d;
            led_q       <= led_d;
        end
    end

    // A BURST entered with zero pulses idles for one cycle to report completion.
    always_comb begin
        counting    = (mode_q == MODE_BLINK) || (mode_q == MODE_BURST);
        burst_empty = (mode_q == MODE_BURST) && (rem_q == '0);
        run         = counting && (period_q != '0) && !burst_empty;
        wrap        = run && (cnt_q == period_q - 1'b1) && !sync_in;
        last        = wrap && (mode_q == MODE_BURST) && (rem_q == BURST_W'(1));
        immediate   = cfg_we && !((cfg_mode == MODE_BLINK) && (mode_q == MODE_BLINK));
        deferred    = cfg_we && !immediate;
        restart     = counting && sync_in;
    end

    always_comb begin
        mode_d      = mode_q;
        period_d    = period_q;
        high_d      = high_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        sh_period_d = sh_period_q;
        sh_high_d   = sh_high_q;
        pend_d      = pend_q;

        unique case (mode_q)
            MODE_OFF: led_d = 1'b0;
            MODE_ON:  led_d = 1'b1;
            default:  led_d = run && !last && (cnt_q < high_q);
        endcase

        if (immediate) begin
            mode_d   = cfg_mode;
            period_d = cfg_period;
            high_d   = cfg_high;
            cnt_d    = '0;
            rem_d    = cfg_count;
            pend_d   = 1'b0;
        end else begin
            if (deferred) begin
                sh_period_d = cfg_period;
                sh_high_d   = cfg_high;
                pend_d      = 1'b1;
            end
            if (wrap || restart) begin
                cnt_d = '0;
                // A write landing on the wrap edge waits for the following wrap.
                if (pend_q && !deferred) begin
                    period_d = sh_period_q;
                    high_d   = sh_high_q;
                    pend_d   = 1'b0;
                end
                if (wrap && (mode_q == MODE_BURST)) begin
                    rem_d = rem_q - 1'b1;
                    if (last) begin
                        mode_d = MODE_OFF;
                    end
                end
            end else if (run) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (burst_empty) begin
                mode_d = MODE_OFF;
            end
        end
    end

    always_comb begin
        led_out    = led_q;
        tick       = wrap;
        burst_done = last || burst_empty;
        pending    = pend_q;
    end

endmodule

// File: rtl/blink_timer_array.sv
// Multi-channel programmable LED/timebase generator. Define BLINK_SYNC_EN to add the
// sync_in port that phase-aligns every counting channel.
module blink_timer_array
    import blink_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 30_000_000,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 25,
    parameter int unsigned BURST_W = 8,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk_30mhz,
    input  logic               rst_n,
`ifdef BLINK_SYNC_EN
    input  logic               sync_in,
`endif
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  mode_t              cfg_mode,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_count,
    output logic [NUM_CH-1:0]  led_out,
    output logic [NUM_CH-1:0]  tick,
    output logic [NUM_CH-1:0]  burst_done,
    output logic [NUM_CH-1:0]  pending
);

    logic sync;

`ifdef BLINK_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    // Channel numbers at or above NUM_CH match no decode and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_we;
        assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

        blink_channel #(
            .CLK_HZ  (CLK_HZ),
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
        ) u_channel (
            .clk_30mhz  (clk_30mhz),
            .rst_n      (rst_n),
            .cfg_we     (ch_we),
            .cfg_mode   (cfg_mode),
            .cfg_period (cfg_period),
            .cfg_high   (cfg_high),
            .cfg_count  (cfg_count),
            .sync_in    (sync),
            .led_out    (led_out[i]),
            .tick       (tick[i]),
            .burst_done (burst_done[i]),
            .pending    (pending[i])
        );
    end

endmodule

// File: tb/tb_blink_timer_array.sv
// Directed bench for blink_timer_array at CLK_HZ=20, CNT_W=8, NUM_CH=4, plus a 3-channel
// instance for the out-of-range channel write; sync steps build only with BLINK_SYNC_EN.
module tb_blink_timer_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we, cfg_we3;
    logic [1:0] cfg_ch, cfg_mode;
    logic [7:0] cfg_period, cfg_high, cfg_count;
    logic [3:0] led, tick, bd, pend;
    logic [2:0] led3, tick3, bd3, pend3;
`ifdef BLINK_SYNC_EN
    logic       sync_in;
`endif

    int tests = 0;
    int fails = 0;
    int k = 0;
    int hi, tk, bdn, bdk;

    always #5 clk = ~clk;

    blink_timer_array #(
        .CLK_HZ  (20),
        .NUM_CH  (4),
        .CNT_W   (8),
        .BURST_W (8)
    ) dut (
        .clk_30mhz  (clk),
        .rst_n      (rst_n),
`ifdef BLINK_SYNC_EN
        .sync_in    (sync_in),
`endif
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_count  (cfg_count),
        .led_out    (led),
        .tick       (tick),
        .burst_done (bd),
        .pending    (pend)
    );

    blink_timer_array #(
        .CLK_HZ  (20),
        .NUM_CH  (3),
        .CNT_W   (8),
        .BURST_W (8)
    ) dut3 (
        .clk_30mhz  (clk),
        .rst_n      (rst_n),
`ifdef BLINK_SYNC_EN
        .sync_in    (1'b0),
`endif
        .cfg_we     (cfg_we3),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_count  (cfg_count),
        .led_out    (led3),
        .tick       (tick3),
        .burst_done (bd3),
        .pending    (pend3)
    );

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic step_to(input int t);
        while (k < t) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] per,
                         input logic [7:0] hig, input logic [7:0] cnt);
        cfg_ch     = ch;
        cfg_mode   = mode;
        cfg_period = per;
        cfg_high   = hig;
        cfg_count  = cnt;
        cfg_we     = 1'b1;
        step();
        cfg_we     = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_we3 = 1'b0;
        cfg_ch = '0; cfg_mode = '0; cfg_period = '0; cfg_high = '0; cfg_count = '0;
`ifdef BLINK_SYNC_EN
        sync_in = 1'b0;
`endif
        release_reset();

        // Default 10 high / 10 low, tick on cycle 19 of each 20.
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_bd", 32'(bd), 32'h0);
        step_to(1);  chk("def_led_hi", 32'(led), 32'hF);
        step_to(5);
        cfg_ch = 2'd3; cfg_mode = 2'd1; cfg_we3 = 1'b1;
        step();
        cfg_we3 = 1'b0;
        step_to(7);  chk("oor_led_hi", 32'(led3), 32'h7);
        step_to(11); chk("def_led_lo", 32'(led), 32'h0);
        step_to(12); chk("oor_led_lo", 32'(led3), 32'h0);
        chk("oor_pend", 32'(pend3), 32'h0);
        step_to(19); chk("def_tick", 32'(tick), 32'hF);
        chk("oor_tick", 32'(tick3), 32'h7);
        step_to(20); chk("def_tick_off", 32'(tick), 32'h0);
        step_to(21); chk("def_led_hi2", 32'(led), 32'hF);

        // Deferred BLINK on ch1 applies at the old period's wrap.
        step_to(25); write(2'd1, 2'd2, 8'd8, 8'd3, 8'd0);
        chk("pend_set", 32'(pend), 32'h2);
        step_to(39); chk("pend_hold", 32'(pend), 32'h2);
        chk("old_tick", 32'(tick), 32'hF);
        step_to(40); chk("pend_clr", 32'(pend), 32'h0);
        step_to(43); chk("new_hi", 32'(led[1]), 32'h1);
        step_to(44); chk("new_lo", 32'(led[1]), 32'h0);
        step_to(47); chk("new_tick", 32'(tick), 32'h2);
        step_to(49); chk("new_hi2", 32'(led[1]), 32'h1);

        // Latest shadow write wins.
        step_to(50); write(2'd1, 2'd2, 8'd10, 8'd5, 8'd0);
        step_to(52); write(2'd1, 2'd2, 8'd4, 8'd1, 8'd0);
        step_to(54); chk("pend_second", 32'(pend), 32'h2);
        step_to(55); chk("tick_p8", 32'(tick[1]), 32'h1);
        step_to(56); chk("pend_clr2", 32'(pend), 32'h0);
        step_to(57); chk("latest_hi", 32'(led[1]), 32'h1);
        step_to(58); chk("latest_lo", 32'(led[1]), 32'h0);
        step_to(61); chk("latest_hi2", 32'(led[1]), 32'h1);

        // BLINK write on the wrap edge waits for the next wrap.
        step_to(63); write(2'd1, 2'd2, 8'd8, 8'd3, 8'd0);
        chk("wrapwr_pend", 32'(pend[1]), 32'h1);
        step_to(67); chk("wrapwr_tick", 32'(tick[1]), 32'h1);
        step_to(68); chk("wrapwr_clr", 32'(pend[1]), 32'h0);
        step_to(71); chk("wrapwr_led", 32'(led[1]), 32'h1);

        // Burst of 3 pulses, 2 cycles each.
        step_to(72); write(2'd2, 2'd3, 8'd4, 8'd2, 8'd3);
        hi = 0; tk = 0; bdn = 0; bdk = 0;
        while (k <= 94) begin
            if (led[2]) hi++;
            if (tick[2]) tk++;
            if (bd[2]) begin bdn++; bdk = k; end
            step();
        end
        chk("burst_high_cycles", 32'(hi), 32'd6);
        chk("burst_ticks", 32'(tk), 32'd3);
        chk("burst_done_count", 32'(bdn), 32'd1);
        chk("burst_done_cycle", 32'(bdk), 32'd84);
        chk("burst_led_off", 32'(led[2]), 32'h0);

        write(2'd2, 2'd3, 8'd4, 8'd2, 8'd0);
        chk("burst0_done", 32'(bd), 32'h4);
        chk("burst0_tick", 32'(tick[2]), 32'h0);
        hi = 0; bdn = 0;
        step();
        while (k <= 101) begin
            if (led[2]) hi++;
            if (bd[2]) bdn++;
            step();
        end
        chk("burst0_no_pulse", 32'(hi), 32'd0);
        chk("burst0_done_once", 32'(bdn), 32'd0);

        // ON, then period=0 holds low with no ticks.
        step_to(101); write(2'd0, 2'd1, 8'd0, 8'd0, 8'd0);
        step_to(103); chk("on_led", 32'(led[0]), 32'h1);
        write(2'd0, 2'd2, 8'd0, 8'd3, 8'd0);
        step_to(105);
        hi = 0; tk = 0;
        while (k <= 129) begin
            if (led[0]) hi++;
            if (tick[0]) tk++;
            step();
        end
        chk("p0_led", 32'(hi), 32'd0);
        chk("p0_tick", 32'(tk), 32'd0);

        // OFF, then high >= period: constant high, tick every 5.
        write(2'd0, 2'd0, 8'd0, 8'd0, 8'd0);
        write(2'd0, 2'd2, 8'd5, 8'd9, 8'd0);
        chk("off_led", 32'(led[0]), 32'h0);
        step();
        hi = 0; tk = 0; bdk = 0;
        while (k <= 151) begin
            if (led[0]) hi++;
            if (tick[0]) begin tk++; if (bdk == 0) bdk = k; end
            step();
        end
        chk("full_high", 32'(hi), 32'd19);
        chk("full_ticks", 32'(tk), 32'd4);
        chk("full_first_tick", 32'(bdk), 32'd136);

        // Reset mid-burst with a pending shadow.
        write(2'd2, 2'd3, 8'd4, 8'd2, 8'd5);
        write(2'd1, 2'd2, 8'd6, 8'd2, 8'd0);
        chk("pre_rst_pend", 32'(pend), 32'h2);
        step_to(155);
        chk("pre_rst_led", 32'(led[0]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_led", 32'(led), 32'h0);
        chk("async_pend", 32'(pend), 32'h0);
        chk("async_tick", 32'(tick), 32'h0);
        chk("async_bd", 32'(bd), 32'h0);
        release_reset();
        step_to(1);  chk("post_led_hi", 32'(led), 32'hF);
        step_to(11); chk("post_led_lo", 32'(led), 32'h0);
        chk("post_pend", 32'(pend), 32'h0);
        step_to(19); chk("post_tick", 32'(tick), 32'hF);
        chk("post_bd", 32'(bd), 32'h0);
        step_to(21); chk("post_led_hi2", 32'(led), 32'hF);

`ifdef BLINK_SYNC_EN
        // Skew ch1 and ch2, then sync on ch0/ch3's final cycle.
        step_to(40); write(2'd1, 2'd1, 8'd0, 8'd0, 8'd0);
        write(2'd1, 2'd2, 8'd20, 8'd10, 8'd0);
        step_to(44); write(2'd2, 2'd3, 8'd20, 8'd10, 8'd5);
        step_to(59);
        sync_in = 1'b1;
        #1;
        chk("sync_tick_suppr", 32'(tick), 32'h0);
        step();
        sync_in = 1'b0;
        tk = 0;
        while (k <= 78) begin
            if (tick != 4'h0) tk++;
            if (k == 61) chk("sync_led_aligned", 32'(led), 32'hF);
            step();
        end
        chk("sync_no_early_tick", 32'(tk), 32'd0);
        chk("sync_tick_aligned", 32'(tick), 32'hF);
        chk("sync_bd", 32'(bd), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
